// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, contact planes, FSM states and ctrl encodings for the pong referee.
package pong_pkg;
    localparam logic [4:0]  PADDLE_X_1    = 5'd19;
    localparam logic [9:0]  PADDLE_X_2    = 10'd616;
    localparam logic [9:0]  PADDLE_WIDTH  = 10'd5;
    localparam logic [9:0]  PADDLE_HEIGHT = 10'd60;
    localparam logic [3:0]  BALL_SIZE     = 4'd10;
    localparam logic [3:0]  WIN_SCORE     = 4'd7;
    localparam logic [25:0] PAUSE_DEFAULT = 26'd25_000_000;
    localparam logic [9:0]  CENTRE_X      = 10'd319;
    // Columns where the ball's leading edge meets each paddle face.
    localparam logic [9:0]  L_PLANE = 10'(PADDLE_X_1) + PADDLE_WIDTH - 10'd1;
    localparam logic [9:0]  R_PLANE = PADDLE_X_2 - 10'(BALL_SIZE) + 10'd1;
    localparam logic [31:0] CTRL_STOP = 32'd0;
    localparam logic [31:0] CTRL_RUN  = 32'd1;
    typedef enum logic [1:0] {IDLE, PLAY, POINT, GAME_OVER} state_t;
endpackage

// File: rtl/pong_referee_if.sv
// pong_referee_if: button, ball/paddle positions in; ctrl word, scores and events out.
interface pong_referee_if;
    logic        start;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y;
    logic [8:0]  paddle_y_1;
    logic [8:0]  paddle_y_2;
    logic [31:0] ctrl;
    logic [3:0]  score_1;
    logic [3:0]  score_2;
    logic        hit_1;
    logic        hit_2;
    logic        game_over;
    logic        winner;
    modport master (output start, ball_x, ball_y, paddle_y_1, paddle_y_2,
                    input  ctrl, score_1, score_2, hit_1, hit_2, game_over, winner);
    modport slave  (input  start, ball_x, ball_y, paddle_y_1, paddle_y_2,
                    output ctrl, score_1, score_2, hit_1, hit_2, game_over, winner);
endinterface

// File: rtl/paddle_contact.sv
// paddle_contact: detects the ball stepping onto one paddle plane and splits it into hit or miss.
module paddle_contact
    import pong_pkg::*;
(
    input  logic [9:0] plane,
    input  logic       left,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_x_q,
    input  logic [8:0] ball_y,
    input  logic [8:0] paddle_y,
    output logic       contact,
    output logic       hit,
    output logic       miss
);
    logic step;
    logic toward;
    logic overlap;
    always_comb begin
        step    = ball_x != ball_x_q;
        toward  = left ? (ball_x < ball_x_q) : (ball_x > ball_x_q);
        // 11-bit sums so paddle_y + height cannot wrap near the bottom edge.
        overlap = ({2'b0, ball_y} + 11'(BALL_SIZE) > {2'b0, paddle_y}) &&
                  ({2'b0, ball_y} < {2'b0, paddle_y} + 11'(PADDLE_HEIGHT));
        contact = step && toward && (ball_x == plane);
        hit     = contact && overlap;
        miss    = contact && !overlap;
    end
endmodule

// File: rtl/pong_referee.sv
// pong_referee: serve/point/game-over sequencing, paddle hit detection and scoring.
module pong_referee
    import pong_pkg::*;
#(
    parameter logic [25:0] PAUSE_CYCLES = PAUSE_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    pong_referee_if.slave bus
);
    state_t      state;
    logic        start_q;
    logic        start_rise;
    logic [9:0]  ball_x_q;
    logic [25:0] pause_cnt;
    logic [3:0]  score_1_next;
    logic [3:0]  score_2_next;
    logic        l_contact, l_hit, l_miss;
    logic        r_contact, r_hit, r_miss;

    paddle_contact u_left (
        .plane(L_PLANE), .left(1'b1), .ball_x(bus.ball_x), .ball_x_q(ball_x_q),
        .ball_y(bus.ball_y), .paddle_y(bus.paddle_y_1),
        .contact(l_contact), .hit(l_hit), .miss(l_miss)
    );

    paddle_contact u_right (
        .plane(R_PLANE), .left(1'b0), .ball_x(bus.ball_x), .ball_x_q(ball_x_q),
        .ball_y(bus.ball_y), .paddle_y(bus.paddle_y_2),
        .contact(r_contact), .hit(r_hit), .miss(r_miss)
    );

    always_comb begin
        start_rise   = bus.start & ~start_q;
        score_1_next = (bus.score_1 == WIN_SCORE) ? WIN_SCORE : bus.score_1 + 4'd1;
        score_2_next = (bus.score_2 == WIN_SCORE) ? WIN_SCORE : bus.score_2 + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            ball_x_q      <= '0;
            pause_cnt     <= '0;
            bus.ctrl      <= CTRL_STOP;
            bus.score_1   <= '0;
            bus.score_2   <= '0;
            bus.hit_1     <= 1'b0;
            bus.hit_2     <= 1'b0;
            bus.game_over <= 1'b0;
            bus.winner    <= 1'b0;
        end else begin
            start_q   <= bus.start;
            ball_x_q  <= bus.ball_x;
            bus.hit_1 <= 1'b0;
            bus.hit_2 <= 1'b0;
            case (state)
                IDLE: if (start_rise) begin
                    state    <= PLAY;
                    bus.ctrl <= CTRL_RUN;
                end
                PLAY: begin
                    // A miss by the left paddle scores for the right player and vice versa.
                    if (l_contact) begin
                        bus.hit_1 <= l_hit;
                        if (l_miss) begin
                            bus.score_2 <= score_2_next;
                            bus.ctrl    <= CTRL_STOP;
                            if (score_2_next == WIN_SCORE) begin
                                state         <= GAME_OVER;
                                bus.game_over <= 1'b1;
                                bus.winner    <= 1'b1;
                            end else begin
                                state     <= POINT;
                                pause_cnt <= '0;
                            end
                        end
                    end
                    if (r_contact) begin
                        bus.hit_2 <= r_hit;
                        if (r_miss) begin
                            bus.score_1 <= score_1_next;
                            bus.ctrl    <= CTRL_STOP;
                            if (score_1_next == WIN_SCORE) begin
                                state         <= GAME_OVER;
                                bus.game_over <= 1'b1;
                                bus.winner    <= 1'b0;
                            end else begin
                                state     <= POINT;
                                pause_cnt <= '0;
                            end
                        end
                    end
                end
                POINT: begin
                    pause_cnt <= pause_cnt + 26'd1;
                    if (pause_cnt == PAUSE_CYCLES - 26'd1) begin
                        state    <= PLAY;
                        bus.ctrl <= CTRL_RUN;
                    end
                end
                GAME_OVER: if (start_rise) begin
                    state         <= PLAY;
                    bus.ctrl      <= CTRL_RUN;
                    bus.score_1   <= '0;
                    bus.score_2   <= '0;
                    bus.game_over <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
